// File: rtl/gps_nco_pkg.sv
// Shared constants and helpers for the GPS code-rate NCO family.
package gps_nco_pkg;

  localparam int unsigned FW_1023K_10M = 32'd439375154;
  localparam int unsigned FW_1023K_20M = 32'd219687577;
  localparam int unsigned GPS_CA_LEN   = 1023;

  function automatic int chip_idx_w(input int len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

endpackage

// File: rtl/gps_code_nco_ch.sv
// One code-rate NCO channel: phase accumulator, shadow/active frequency word, chip counter, strobes.
// Optional PHASE_OUT_EN adds a registered {chip_idx, acc[MSB-:16]} fractional code phase.
module gps_code_nco_ch
  import gps_nco_pkg::*;
#(
  parameter int               ACC_W    = 32,
  parameter int               CODE_LEN = GPS_CA_LEN,
  parameter logic [ACC_W-1:0] FW_INIT  = ACC_W'(FW_1023K_10M),
  localparam int              IW       = chip_idx_w(CODE_LEN)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             wr_hit,
  input  logic [ACC_W-1:0] wr_data,
  input  logic             restart,
  output logic             clk_code,
  output logic             chip_en,
  output logic             epoch,
  output logic [IW-1:0]    chip_idx
`ifdef PHASE_OUT_EN
  ,
  output logic [IW+15:0]   code_phase
`endif
);

  localparam logic [IW-1:0] LAST_CHIP = IW'(CODE_LEN - 1);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] fw_act;
  logic [ACC_W-1:0] fw_shd;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             commit;
  logic [ACC_W-1:0] acc_next;
  logic [IW-1:0]    idx_next;

  always_comb begin
    sum      = {1'b0, acc} + {1'b0, fw_act};
    carry    = sum[ACC_W];
    // restart suppresses both the carry and the epoch commit
    commit   = carry && (chip_idx == LAST_CHIP) && !restart;
    acc_next = restart ? '0 : sum[ACC_W-1:0];
    idx_next = chip_idx;
    if (restart) begin
      idx_next = '0;
    end else if (carry) begin
      idx_next = (chip_idx == LAST_CHIP) ? '0 : chip_idx + IW'(1);
    end
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      acc      <= '0;
      fw_act   <= FW_INIT;
      fw_shd   <= FW_INIT;
      chip_idx <= '0;
      chip_en  <= 1'b0;
      epoch    <= 1'b0;
      clk_code <= 1'b0;
    end else begin
      acc      <= acc_next;
      chip_idx <= idx_next;
      chip_en  <= carry && !restart;
      epoch    <= commit;
      clk_code <= acc_next[ACC_W-1];
      if (wr_hit) begin
        fw_shd <= wr_data;
      end
      // a same-cycle write beats the shadow copy; a stopped channel takes a write at once
      if (wr_hit && (commit || fw_act == '0)) begin
        fw_act <= wr_data;
      end else if (commit) begin
        fw_act <= fw_shd;
      end
    end
  end

`ifdef PHASE_OUT_EN
  logic [15:0] frac_next;

  if (ACC_W >= 16) begin : g_frac_wide
    assign frac_next = acc_next[ACC_W-1 -: 16];
  end else begin : g_frac_narrow
    assign frac_next = {acc_next, {(16 - ACC_W){1'b0}}};
  end

  always_ff @(posedge clkin or posedge rst) begin
    if (rst) begin
      code_phase <= '0;
    end else begin
      code_phase <= {idx_next, frac_next};
    end
  end
`endif

endmodule

// File: rtl/gps_code_nco_mc.sv
// Multi-channel GPS code-rate NCO: write-address decode plus one gps_code_nco_ch per channel.
// Optional PHASE_OUT_EN adds the packed code_phase output.
module gps_code_nco_mc
  import gps_nco_pkg::*;
#(
  parameter int               NUM_CH   = 4,
  parameter int               ACC_W    = 32,
  parameter int               CODE_LEN = GPS_CA_LEN,
  parameter logic [ACC_W-1:0] FW_INIT  = ACC_W'(FW_1023K_10M),
  localparam int              CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int              IW       = chip_idx_w(CODE_LEN)
) (
  input  logic                 clkin,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [CH_W-1:0]      wr_ch,
  input  logic [ACC_W-1:0]     wr_data,
  input  logic [NUM_CH-1:0]    restart,
  output logic [NUM_CH-1:0]    clk_code,
  output logic [NUM_CH-1:0]    chip_en,
  output logic [NUM_CH-1:0]    epoch,
  output logic [NUM_CH*IW-1:0] chip_idx
`ifdef PHASE_OUT_EN
  ,
  output logic [NUM_CH*(IW+16)-1:0] code_phase
`endif
);

  // Channel numbers at or above NUM_CH match no SEL and are dropped here.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] SEL = CH_W'(g);
    logic wr_hit;

    assign wr_hit = wr_en && (wr_ch == SEL);

    gps_code_nco_ch #(
      .ACC_W    (ACC_W),
      .CODE_LEN (CODE_LEN),
      .FW_INIT  (FW_INIT)
    ) u_ch (
      .clkin      (clkin),
      .rst        (rst),
      .wr_hit     (wr_hit),
      .wr_data    (wr_data),
      .restart    (restart[g]),
      .clk_code   (clk_code[g]),
      .chip_en    (chip_en[g]),
      .epoch      (epoch[g]),
      .chip_idx   (chip_idx[g*IW +: IW])
`ifdef PHASE_OUT_EN
      ,
      .code_phase (code_phase[g*(IW+16) +: IW+16])
`endif
    );
  end

endmodule

// File: tb/tb_gps_code_nco_mc.sv
// Self-checking bench for gps_code_nco_mc (2 channels, 8-bit accumulator, 4-chip code).
// Directed scenarios plus random writes/restarts, all compared against a cycle-level arithmetic model.
module tb_gps_code_nco_mc;

  localparam int NUM_CH   = 2;
  localparam int ACC_W    = 8;
  localparam int CODE_LEN = 4;
  localparam int IW       = 2;
  localparam int MODULUS  = 256;
  localparam int FW_RST   = 64;

  logic                 clkin;
  logic                 rst;
  logic                 wr_en;
  logic [0:0]           wr_ch;
  logic [ACC_W-1:0]     wr_data;
  logic [NUM_CH-1:0]    restart;
  logic [NUM_CH-1:0]    clk_code;
  logic [NUM_CH-1:0]    chip_en;
  logic [NUM_CH-1:0]    epoch;
  logic [NUM_CH*IW-1:0] chip_idx;
`ifdef PHASE_OUT_EN
  logic [NUM_CH*(IW+16)-1:0] code_phase;
`endif

  int n_checks;
  int n_err;

  // Reference model state: phase in [0, 256), words and chip number as plain integers
  int m_phase [NUM_CH];
  int m_fw    [NUM_CH];
  int m_shd   [NUM_CH];
  int m_idx   [NUM_CH];
  bit m_en    [NUM_CH];
  bit m_ep    [NUM_CH];
  bit m_clk   [NUM_CH];

  gps_code_nco_mc #(
    .NUM_CH   (NUM_CH),
    .ACC_W    (ACC_W),
    .CODE_LEN (CODE_LEN),
    .FW_INIT  (8'd64)
  ) dut (
    .clkin      (clkin),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_ch      (wr_ch),
    .wr_data    (wr_data),
    .restart    (restart),
    .clk_code   (clk_code),
    .chip_en    (chip_en),
    .epoch      (epoch),
    .chip_idx   (chip_idx)
`ifdef PHASE_OUT_EN
    ,
    .code_phase (code_phase)
`endif
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_phase[c] = 0;
      m_fw[c]    = FW_RST;
      m_shd[c]   = FW_RST;
      m_idx[c]   = 0;
      m_en[c]    = 1'b0;
      m_ep[c]    = 1'b0;
      m_clk[c]   = 1'b0;
    end
  endfunction

  function automatic bit will_carry(input int c);
    return (m_phase[c] + m_fw[c]) >= MODULUS;
  endfunction

  function automatic bit will_epoch(input int c);
    return will_carry(c) && (m_idx[c] == CODE_LEN - 1);
  endfunction

  function automatic void model_step(input bit we, input int ch, input int d, input bit [1:0] rs);
    for (int c = 0; c < NUM_CH; c++) begin
      int  total;
      bit  wrapped;
      bit  hit;
      bit  at_epoch;
      int  new_fw;
      total    = m_phase[c] + m_fw[c];
      wrapped  = total >= MODULUS;
      hit      = we && (ch == c);
      at_epoch = wrapped && (m_idx[c] == CODE_LEN - 1);
      new_fw   = m_fw[c];
      if (rs[c]) begin
        m_phase[c] = 0;
        m_idx[c]   = 0;
        m_en[c]    = 1'b0;
        m_ep[c]    = 1'b0;
        if (hit && m_fw[c] == 0) new_fw = d;
      end else begin
        m_phase[c] = total % MODULUS;
        m_en[c]    = wrapped;
        m_ep[c]    = at_epoch;
        if (wrapped) m_idx[c] = (m_idx[c] + 1) % CODE_LEN;
        if (at_epoch) new_fw = hit ? d : m_shd[c];
        else if (hit && m_fw[c] == 0) new_fw = d;
      end
      if (hit) m_shd[c] = d;
      m_fw[c]  = new_fw;
      m_clk[c] = m_phase[c] >= MODULUS / 2;
    end
  endfunction

  function automatic logic [63:0] exp_outputs();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[c]                       = m_clk[c];
      v[NUM_CH + c]              = m_en[c];
      v[2*NUM_CH + c]            = m_ep[c];
      v[3*NUM_CH + IW*c +: IW]   = IW'(m_idx[c]);
    end
    return v;
  endfunction

`ifdef PHASE_OUT_EN
  function automatic logic [63:0] exp_phase();
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      v[(IW+16)*c +: IW+16] = {IW'(m_idx[c]), 8'(m_phase[c]), 8'h00};
    end
    return v;
  endfunction
`endif

  function automatic logic [63:0] obs_outputs();
    return 64'({chip_idx, epoch, chip_en, clk_code});
  endfunction

  task automatic applyStimulus(input bit we, input int ch, input int d, input bit [1:0] rs);
    wr_en   = we;
    wr_ch   = 1'(ch);
    wr_data = 8'(d);
    restart = rs;
    model_step(we, ch, d, rs);
    @(posedge clkin);
    #1;
    checkOutput("outputs", obs_outputs(), exp_outputs());
`ifdef PHASE_OUT_EN
    checkOutput("code_phase", 64'(code_phase), exp_phase());
`endif
    wr_en   = 1'b0;
    restart = '0;
  endtask

  initial begin
    int first_chip;
    int ep_cycle;
    int clk_high;
    int idx_seq;
    int cnt;
    bit found;

    n_checks = 0;
    n_err    = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_ch    = '0;
    wr_data  = '0;
    restart  = '0;
    model_reset();

    repeat (3) @(posedge clkin);
    #1;
    checkOutput("reset_state", obs_outputs(), 64'd0);
    checkOutput("reset_fw_act0", 64'(dut.g_ch[0].u_ch.fw_act), 64'(FW_RST));
    rst = 1'b0;

    // Free run from reset: chip every 4 cycles, epoch every 16, clk_code 2 high of 4
    first_chip = 0; ep_cycle = 0; clk_high = 0; idx_seq = 0;
    for (int k = 1; k <= 16; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (chip_en[0]) begin
        if (first_chip == 0) first_chip = k;
        idx_seq = idx_seq * 4 + int'(chip_idx[1:0]);
      end
      if (epoch[0]) ep_cycle = k;
      if (clk_code[0]) clk_high++;
    end
    checkOutput("first_chip_latency", 64'(first_chip), 64'd4);
    checkOutput("idx_sequence", 64'(idx_seq), 64'd108);
    checkOutput("epoch_cycle", 64'(ep_cycle), 64'd16);
    checkOutput("clk_high_cycles", 64'(clk_high), 64'd8);

    // Write 128 to channel 1 at chip 1: takes effect only after its next epoch
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (int'(chip_idx[3:2]) == 1) found = 1'b1;
      else applyStimulus(1'b0, 0, 0, 2'b00);
    end
    checkOutput("wait_ch1_idx1", 64'(found), 64'd1);
    applyStimulus(1'b1, 1, 128, 2'b00);
    checkOutput("ch1_shd_after_write", 64'(dut.g_ch[1].u_ch.fw_shd), 64'd128);
    checkOutput("ch1_act_before_epoch", 64'(dut.g_ch[1].u_ch.fw_act), 64'd64);
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (epoch[1]) found = 1'b1;
    end
    checkOutput("wait_ch1_epoch", 64'(found), 64'd1);
    checkOutput("ch1_act_after_epoch", 64'(dut.g_ch[1].u_ch.fw_act), 64'd128);
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (chip_en[1]) cnt++;
    end
    checkOutput("ch1_chips_in_8", 64'(cnt), 64'd4);

    // Write 32 to channel 0 exactly in its epoch-condition cycle
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (will_epoch(0)) found = 1'b1;
      else applyStimulus(1'b0, 0, 0, 2'b00);
    end
    checkOutput("wait_ch0_epoch_cond", 64'(found), 64'd1);
    applyStimulus(1'b1, 0, 32, 2'b00);
    checkOutput("ch0_shd_at_epoch", 64'(dut.g_ch[0].u_ch.fw_shd), 64'd32);
    checkOutput("ch0_act_at_epoch", 64'(dut.g_ch[0].u_ch.fw_act), 64'd32);
    cnt = 0;
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (chip_en[0]) cnt++;
    end
    checkOutput("ch0_chips_in_16", 64'(cnt), 64'd2);

    // Stop channel 0 at its epoch, then restart it with a plain write
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (will_epoch(0)) found = 1'b1;
      else applyStimulus(1'b0, 0, 0, 2'b00);
    end
    checkOutput("wait_ch0_epoch_stop", 64'(found), 64'd1);
    applyStimulus(1'b1, 0, 0, 2'b00);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      applyStimulus(k == 0, 1, 64, 2'b00);
      if (chip_en[0]) cnt++;
    end
    checkOutput("ch0_stopped_chips", 64'(cnt), 64'd0);
    applyStimulus(1'b1, 0, 64, 2'b00);
    cnt = 0;
    for (int k = 1; k <= 20 && cnt == 0; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (chip_en[0]) cnt = k;
    end
    checkOutput("ch0_idle_start_latency", 64'(cnt), 64'd4);

    // Restart channel 1 in a carry cycle
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (will_carry(1)) found = 1'b1;
      else applyStimulus(1'b0, 0, 0, 2'b00);
    end
    checkOutput("wait_ch1_carry", 64'(found), 64'd1);
    applyStimulus(1'b0, 0, 0, 2'b10);
    checkOutput("restart_chip_en1", 64'(chip_en[1]), 64'd0);
    checkOutput("restart_idx1", 64'(chip_idx[3:2]), 64'd0);
    cnt = 0;
    for (int k = 1; k <= 20 && cnt == 0; k++) begin
      applyStimulus(1'b0, 0, 0, 2'b00);
      if (chip_en[1]) cnt = k;
    end
    checkOutput("restart_next_chip", 64'(cnt), 64'd4);

    // Random writes and restarts
    for (int k = 0; k < 400; k++) begin
      bit [1:0] rs;
      rs[0] = ($urandom_range(0, 15) == 0);
      rs[1] = ($urandom_range(0, 15) == 0);
      applyStimulus($urandom_range(0, 5) == 0, int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 255)), rs);
    end

    // Asynchronous reset in the middle of a cycle
    found = 1'b0;
    for (int k = 0; k < 64 && !found; k++) begin
      if (obs_outputs() != 64'd0) found = 1'b1;
      else applyStimulus(1'b0, 0, 0, 2'b00);
    end
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_outputs", obs_outputs(), 64'd0);
`ifdef PHASE_OUT_EN
    checkOutput("async_rst_code_phase", 64'(code_phase), 64'd0);
`endif
    checkOutput("async_rst_fw_act0", 64'(dut.g_ch[0].u_ch.fw_act), 64'(FW_RST));
    checkOutput("async_rst_fw_act1", 64'(dut.g_ch[1].u_ch.fw_act), 64'(FW_RST));
    checkOutput("async_rst_fw_shd1", 64'(dut.g_ch[1].u_ch.fw_shd), 64'(FW_RST));
    model_reset();
    @(posedge clkin);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 12; k++) applyStimulus(1'b0, 0, 0, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/gps_code_nco_mc.md
# gps_code_nco_mc

Multi-channel, parametrised GPS code-rate NCO. Each of NUM_CH channels runs an ACC_W-bit phase accumulator driven by its own run-time frequency word and produces a 50 %-duty code clock, a one-cycle chip strobe, a chip index modulo CODE_LEN and a code-epoch strobe. It sits between the reference-clock domain and the C/A code generators and correlators, and supersedes the fixed-word single-channel 1.023 MHz divider. Frequency-word updates are double-buffered and take effect only on a code epoch, so code phase is never corrupted mid-period.

## Interface
- NUM_CH, 4: number of independent channels (1..16)
- ACC_W, 32: phase accumulator and frequency word width
- CODE_LEN, 1023: chips per code epoch
- FW_INIT, 32'd439375154: frequency word loaded at reset into every channel
- clkin  in  1  sole clock; all state is updated on its rising edge
- rst  in  1  asynchronous, active-high reset
- wr_en  in  1  frequency-word write strobe
- wr_ch  in  $clog2(NUM_CH) (min 1)  target channel for wr_data
- wr_data  in  ACC_W  new frequency word
- restart  in  NUM_CH  per-channel synchronous phase restart
- clk_code  out  NUM_CH  per-channel code clock, equal to accumulator MSB, registered
- chip_en  out  NUM_CH  one-cycle strobe per chip boundary
- epoch  out  NUM_CH  one-cycle strobe when chip index wraps to 0
- chip_idx  out  NUM_CH*$clog2(CODE_LEN)  packed chip index, channel 0 in the LSBs

## Operation
- Per channel: acc <= acc + fw_act modulo 2^ACC_W. carry is the (ACC_W+1)-th bit of the sum.
- chip_en[ch] <= carry. On carry, chip_idx <= (chip_idx == CODE_LEN-1) ? 0 : chip_idx+1. epoch[ch] <= carry && chip_idx == CODE_LEN-1.
- clk_code[ch] is the MSB of the acc register. Its frequency is fclk·fw_act/2^ACC_W with about 50 % duty. FW_INIT therefore yields 1.023 MHz at clkin = 10 MHz.
- Write path: wr_en with wr_ch == ch loads fw_shd[ch]. A wr_ch value of NUM_CH or above is ignored.
- Epoch commit: in the cycle where the epoch condition is true (carry at chip CODE_LEN-1), fw_act <= fw_shd.
  - If a write to the same channel happens in that same cycle, wr_data goes to both fw_shd and fw_act. The write wins.
- Idle start: if fw_act == 0, the channel produces no carry. A write then loads fw_act immediately as well as fw_shd, so a stopped channel can be started.
- restart[ch] clears acc, chip_idx, chip_en, epoch and clk_code on the next edge and keeps fw_act and fw_shd.
  - restart takes priority over carry and over the epoch commit in the same cycle.
  - A write in that same cycle is still accepted.
- Channels are fully independent. No cross-channel arithmetic is performed.

## Timing
- Reset values: acc 0, fw_act = fw_shd = FW_INIT, chip_idx 0, clk_code 0, chip_en 0, epoch 0.
- Latency: chip_en and epoch are high in the cycle after the edge on which the wrapping add is registered. chip_idx updates on the same edge that sets chip_en.
- After reset or restart with frequency word F, the first chip_en occurs ceil(2^ACC_W/F) cycles later.
- New fw_act is used for the first add after the commit edge. The accumulator is not reset on commit, so phase is continuous.
- If fw_act ≥ 2^(ACC_W-1), chip_en can assert on consecutive cycles. This is legal, but clk_code is then aliased.
- fw_act == 2^ACC_W-1 is legal. A carry occurs on every cycle except the first.

## Configuration
- PHASE_OUT_EN defined: adds output code_phase, NUM_CH*($clog2(CODE_LEN)+16) bits.
  - Per channel the field is {chip_idx, acc[ACC_W-1 -: 16]}, registered and aligned with chip_idx.
  - It gives the fractional code phase to the tracking loops.
- PHASE_OUT_EN undefined: the port and its registers are absent. All other behaviour is identical.

## Structure
- Shared package gps_nco_pkg holds:
  - FW_1023K_10M (439375154)
  - FW_1023K_20M (219687577)
  - GPS_CA_LEN (1023)
  - function chip_idx_w(len) returning $clog2(len)
- One sub-module, gps_code_nco_ch, contains one channel: accumulator, shadow/active word, chip counter and strobes.
  - The top level holds write-address decode and a generate loop over NUM_CH.

## Test plan
- Reset, then measure clk_code period per channel. Parameters: NUM_CH=2, ACC_W=8, CODE_LEN=4, FW_INIT=64.
  - Required: chip_en every 4 cycles, first chip_en 4 cycles after rst deasserts.
  - Required: epoch every 16 cycles, chip_idx sequence 1,2,3,0.
  - Required: clk_code period 4 cycles, high 2 cycles.
- Write 128 to channel 1 at chip_idx 1. Required: spacing stays 4 until after the next epoch, then becomes 2. Channel 0 is unaffected.
- Write 32 to channel 0 in the same cycle as its epoch strobe condition. Required: spacing becomes 8 immediately after that edge, and fw_shd = 32.
- Set fw_act to 0 via a write at the epoch, then write 64. Required: no chip_en while stopped; the first chip_en arrives 4 cycles after the second write's edge.
- Pulse restart[1] together with a carry on channel 1. Required: chip_en[1] stays 0, chip_idx[1] = 0, and the next chip_en arrives 4 cycles later.
- Assert rst asynchronously mid-epoch. Required: all outputs are 0 in the same cycle and fw_act returns to FW_INIT. With PHASE_OUT_EN defined, check code_phase = {chip_idx, acc[7:0]} padded to 16 bits each cycle.
